// File: rtl/fifo_pkg.sv
// Shared constants and the drain-controller state type for the FIFO drain block.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH    = 16;
  localparam int unsigned FIFO_DEPTH    = 16;
  localparam int unsigned BURST_LEN_DEF = 4;
  localparam int unsigned WORD_CNT_W    = 16;
  localparam int unsigned BCNT_W        = 8;
  localparam int unsigned SKID_CNT_W    = 2;
  localparam int unsigned OCC_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus outgoing stream; master is the drain controller side.
interface fifo_drain_if #(
  parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH
) ();

  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             underflow;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output rd_en,
    input  data_out,
    input  empty,
    input  underflow,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last
  );

  modport slave (
    input  rd_en,
    output data_out,
    output empty,
    output underflow,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer; entry 0 is always the oldest word.
module fifo_skid_buf #(
  parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    out_data,
  input  logic                                out_ready,
  output logic [fifo_pkg::SKID_CNT_W-1:0]     count
);
  import fifo_pkg::*;

  logic [WIDTH-1:0]      ent0;
  logic [WIDTH-1:0]      ent1;
  logic [SKID_CNT_W-1:0] cnt;
  logic                  pop;

  assign pop       = out_ready && (cnt != '0);
  assign out_valid = (cnt != '0);
  assign out_data  = ent0;
  assign count     = cnt;

  // Caller guarantees no push into a full buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      unique case ({in_valid, pop})
        2'b10: begin
          if (cnt == '0) ent0 <= in_data;
          else           ent1 <= in_data;
          cnt <= cnt + SKID_CNT_W'(1);
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - SKID_CNT_W'(1);
        end
        2'b11: begin
          if (cnt == SKID_CNT_W'(1)) begin
            ent0 <= in_data;
          end else begin
            ent0 <= ent1;
            ent1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Drains a synchronous FIFO into a valid/ready stream framed in fixed-length bursts.
module fifo_drain #(
  parameter int unsigned FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int unsigned BURST_LEN  = fifo_pkg::BURST_LEN_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              drain_en,
  fifo_drain_if.master                      bus,
  output logic [fifo_pkg::WORD_CNT_W-1:0]   word_cnt,
  output logic                              underflow_err,
  output logic                              busy
);
  import fifo_pkg::*;

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_LEN - 1);

  drain_state_e          state;
  drain_state_e          state_nxt;
  logic                  inflight;
  logic [SKID_CNT_W-1:0] count;
  logic                  head_valid;
  logic [FIFO_WIDTH-1:0] head;
  logic [BCNT_W-1:0]     bcnt;
  logic                  xfer_c;
  logic                  rd_c;
  logic [OCC_W-1:0]      occ_c;

  fifo_skid_buf #(.WIDTH(FIFO_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight),
    .in_data   (bus.data_out),
    .out_valid (head_valid),
    .out_data  (head),
    .out_ready (bus.m_ready),
    .count     (count)
  );

  assign xfer_c      = head_valid && bus.m_ready;
  assign bus.rd_en   = rd_c;
  assign bus.m_valid = head_valid;
  assign bus.m_data  = head;
  assign bus.m_last  = head_valid && (bcnt == BCNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Occupancy excludes the word leaving this cycle so reads can sustain one per cycle.
  always_comb begin
    state_nxt = state;
    occ_c     = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(xfer_c);
    rd_c      = 1'b0;
    unique case (state)
      IDLE: if (drain_en) state_nxt = RUN;
      RUN: begin
        if (!drain_en) state_nxt = STOP;
        rd_c = rst_n && drain_en && !bus.empty && (occ_c < OCC_W'(2));
      end
      STOP: begin
        if (drain_en)                          state_nxt = RUN;
        else if (!inflight && (count == '0))   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_c already implies the FIFO was non-empty, so it marks an issued read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      busy          <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      inflight      <= rd_c;
      busy          <= (state_nxt != IDLE);
      underflow_err <= underflow_err | bus.underflow;
    end
  end

  // Burst position survives STOP/IDLE so framing resumes mid-burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt     <= '0;
      word_cnt <= '0;
    end else if (xfer_c) begin
      word_cnt <= word_cnt + WORD_CNT_W'(1);
      if (bcnt == BCNT_LAST) bcnt <= '0;
      else                   bcnt <= bcnt + BCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Randomized and directed bench for fifo_drain against a queue-based stream model.
module tb_fifo_drain;

  localparam int W  = 16;
  localparam int BL = 4;

  typedef struct {
    logic [W-1:0] w;
    int           avail;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          drain_en;
  logic [15:0]   word_cnt;
  logic          underflow_err;
  logic          busy;

  fifo_drain_if #(.WIDTH(W)) bus ();

  fifo_drain #(.FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drain_en      (drain_en),
    .bus           (bus),
    .word_cnt      (word_cnt),
    .underflow_err (underflow_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] src[$];
  ent_t         exp_q[$];
  logic [W-1:0] pend_word;
  logic         pend_valid;
  int           cyc;
  int           beats;
  int           n_checks;
  int           n_errors;
  logic         uf_model;
  logic         armed;
  logic         o_rd, o_xf, o_valid, o_last;
  logic [W-1:0] o_data;

  logic [W-1:0] xd[16];
  logic         xl[16];
  int           xc[16];
  int           nx, nrd, nv, c0, first, k;
  logic [W-1:0] held;
  logic         have;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive FIFO side, check outputs against the model, advance the model.
  task automatic tick();
    logic exp_valid;
    bus.empty    = (src.size() == 0);
    bus.data_out = pend_valid ? pend_word : W'($urandom);
    #1;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    o_rd    = bus.rd_en && !bus.empty;
    o_valid = bus.m_valid;
    o_data  = bus.m_data;
    o_last  = bus.m_last;
    o_xf    = bus.m_valid && bus.m_ready;
    if (rst_n && armed) begin
      chk("valid", 32'(bus.m_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("data", 32'(bus.m_data), 32'(exp_q[0].w));
        chk("last", 32'(bus.m_last), 32'((beats % BL) == BL - 1));
      end
      chk("rd_while_empty", 32'(bus.rd_en & bus.empty), 0);
      chk("rd_while_off", 32'(bus.rd_en & ~drain_en), 0);
      chk("word_cnt", 32'(word_cnt), 32'(beats % 65536));
      chk("underflow_err", 32'(underflow_err), 32'(uf_model));
    end
    pend_valid = 1'b0;
    if (o_rd) begin
      pend_word  = src.pop_front();
      pend_valid = 1'b1;
    end
    if (!rst_n) begin
      exp_q.delete();
      beats    = 0;
      uf_model = 1'b0;
      armed    = 1'b1;
    end else begin
      if (o_rd) exp_q.push_back('{w: pend_word, avail: cyc + 2});
      if (exp_valid && bus.m_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
      if (bus.underflow) uf_model = 1'b1;
      if (armed) chk("read_ahead", 32'(exp_q.size() <= 2), 1);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_state(input string p);
    chk({p, "_m_valid"}, 32'(bus.m_valid), 0);
    chk({p, "_m_last"}, 32'(bus.m_last), 0);
    chk({p, "_m_data"}, 32'(bus.m_data), 0);
    chk({p, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({p, "_word_cnt"}, 32'(word_cnt), 0);
    chk({p, "_underflow_err"}, 32'(underflow_err), 0);
    chk({p, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_idle(input int bound);
    drain_en = 1'b0;
    for (int c = 0; c < bound && busy !== 1'b0; c++) tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; beats = 0;
    uf_model = 1'b0; armed = 1'b0; pend_valid = 1'b0; pend_word = '0;
    rst_n = 1'b0; drain_en = 1'b0;
    bus.m_ready = 1'b0; bus.underflow = 1'b0; bus.empty = 1'b1; bus.data_out = '0;
    o_rd = 1'b0; o_xf = 1'b0; o_valid = 1'b0; o_last = 1'b0; o_data = '0;
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;
    check_reset_state("rst");

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) src.push_back(W'(i));
    drain_en = 1'b1; bus.m_ready = 1'b1; nx = 0;
    tick();
    chk("s_busy", 32'(busy), 1);
    for (int c = 0; c < 40 && nx < 8; c++) begin
      c0 = cyc;
      tick();
      if (o_xf) begin xd[nx] = o_data; xl[nx] = o_last; xc[nx] = c0; nx++; end
    end
    chk("s_count", 32'(nx), 8);
    for (int i = 0; i < 8; i++) begin
      chk("s_data", 32'(xd[i]), 32'(i + 1));
      chk("s_last", 32'(xl[i]), 32'((i % BL) == BL - 1));
      if (i > 0) chk("s_gap", 32'(xc[i] - xc[i-1]), 1);
    end
    chk("s_word_cnt", 32'(word_cnt), 8);
    wait_idle(10);
    chk("s_idle", 32'(busy), 0);

    // Backpressure: 5-cycle stall mid-stream
    for (int i = 0; i < 12; i++) src.push_back(W'($urandom));
    drain_en = 1'b1; bus.m_ready = 1'b1; nx = 0;
    repeat (4) begin tick(); if (o_xf) nx++; end
    bus.m_ready = 1'b0; have = 1'b0; held = '0;
    repeat (5) begin
      tick();
      if (o_valid) begin
        if (have) chk("b_hold", 32'(o_data), 32'(held));
        held = o_data; have = 1'b1;
      end
    end
    chk("b_ahead", 32'(exp_q.size()), 2);
    chk("b_valid", 32'(bus.m_valid), 1);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 60 && (src.size() > 0 || exp_q.size() > 0); c++) begin
      tick(); if (o_xf) nx++;
    end
    chk("b_count", 32'(nx), 12);

    // Stop one cycle after the first read, then restart mid-burst
    wait_idle(10);
    for (int i = 0; i < 6; i++) src.push_back(W'($urandom));
    drain_en = 1'b1; bus.m_ready = 1'b1; nx = 0; nrd = 0; o_rd = 1'b0;
    for (int c = 0; c < 10 && !o_rd; c++) tick();
    chk("t_read", 32'(o_rd), 1);
    drain_en = 1'b0;
    repeat (8) begin tick(); if (o_rd) nrd++; if (o_xf) nx++; end
    chk("t_rd_after", 32'(nrd), 0);
    chk("t_delivered", 32'(nx), 1);
    chk("t_src_left", 32'(src.size()), 5);
    chk("t_idle", 32'(busy), 0);
    k = (BL - 1 - (beats % BL)) % BL;
    first = -1; nx = 0; drain_en = 1'b1;
    for (int c = 0; c < 40 && (src.size() > 0 || exp_q.size() > 0); c++) begin
      tick();
      if (o_xf) begin
        if (o_last && first < 0) first = nx;
        nx++;
      end
    end
    chk("t_resume_last", 32'(first), 32'(k));
    chk("t_resume_cnt", 32'(nx), 5);

    // Empty FIFO throughout RUN
    wait_idle(10);
    drain_en = 1'b1; nrd = 0; nv = 0;
    repeat (10) begin tick(); if (o_rd) nrd++; if (o_valid) nv++; end
    chk("e_rd", 32'(nrd), 0);
    chk("e_valid", 32'(nv), 0);
    chk("e_busy", 32'(busy), 1);

    // Single-cycle underflow pulse is sticky
    bus.underflow = 1'b1;
    tick();
    bus.underflow = 1'b0;
    chk("u_set", 32'(underflow_err), 1);
    repeat (5) tick();
    chk("u_hold", 32'(underflow_err), 1);

    // Reset with two words buffered
    for (int i = 0; i < 4; i++) src.push_back(W'($urandom));
    drain_en = 1'b1; bus.m_ready = 1'b0;
    for (int c = 0; c < 20 && !(exp_q.size() == 2 && exp_q[1].avail <= cyc); c++) tick();
    chk("r_buffered", 32'(exp_q.size()), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; drain_en = 1'b0; src.delete();
    check_reset_state("r");

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      drain_en      = ($urandom_range(0, 9) != 0);
      bus.m_ready   = ($urandom_range(0, 3) != 0);
      bus.underflow = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0 && src.size() < 8) src.push_back(W'($urandom));
      tick();
    end
    drain_en = 1'b1; bus.m_ready = 1'b1; bus.underflow = 1'b0;
    for (int c = 0; c < 100 && (src.size() > 0 || exp_q.size() > 0); c++) tick();
    chk("end_drained", 32'(src.size() + exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
